// File: rtl/rh_pkg.sv
// rtl/rh_pkg.sv - shared constants and FSM state type for the RowHammer pattern sequencer
package rh_pkg;
   localparam logic [2:0] OP_ACT = 3'b001;
   localparam logic [2:0] OP_PRE = 3'b010;
   localparam logic [2:0] OP_RH  = 3'b111;

   localparam int INSTR_OP_LSB   = 29;
   localparam int INSTR_OP_W     = 3;
   localparam int INSTR_BANK_LSB = 26;
   localparam int INSTR_ROW_LSB  = 0;

   localparam logic MODE_LINEAR = 1'b0;
   localparam logic MODE_DOUBLE = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ISSUE,
      ST_WAIT_ACK,
      ST_DONE
   } rh_state_e;
endpackage

// File: rtl/rh_row_stepper.sv
// rtl/rh_row_stepper.sv - incremental aggressor row generator with list index and side select
module rh_row_stepper
   import rh_pkg::*;
#(
   parameter int ROW_WIDTH = 15,
   parameter int AW        = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_load,
   input  logic                 i_step,
   input  logic [ROW_WIDTH-1:0] i_base,
   input  logic [ROW_WIDTH-1:0] i_stride,
   input  logic [AW-1:0]        i_num,
   input  logic                 i_mode,
   output logic [ROW_WIDTH-1:0] o_row,
   output logic                 o_last_pair
);
   logic [ROW_WIDTH-1:0] r_cur;
   logic [AW-1:0]        r_idx;
   logic                 r_side;
   logic                 w_last_entry;

   assign w_last_entry = (r_idx == AW'(i_num - 1'b1));
   assign o_last_pair  = w_last_entry && ((i_mode == MODE_LINEAR) || r_side);

   // In double-sided mode r_cur is the victim; the emitted row straddles it.
   assign o_row = (i_mode == MODE_DOUBLE) ?
                  (r_side ? r_cur + ROW_WIDTH'(1) : r_cur - ROW_WIDTH'(1)) : r_cur;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cur  <= '0;
         r_idx  <= '0;
         r_side <= 1'b0;
      end else if (i_load) begin
         r_cur  <= i_base;
         r_idx  <= '0;
         r_side <= 1'b0;
      end else if (i_step) begin
         if ((i_mode == MODE_DOUBLE) && !r_side) begin
            r_side <= 1'b1;
         end else begin
            r_side <= 1'b0;
            if (w_last_entry) begin
               r_idx <= '0;
               r_cur <= i_base;
            end else begin
               r_idx <= r_idx + 1'b1;
               r_cur <= r_cur + i_stride;
            end
         end
      end
   end
endmodule

// File: rtl/rh_pattern_sequencer.sv
// rtl/rh_pattern_sequencer.sv - multi-aggressor ACT/PRE RowHammer pair generator for the dispatcher slots
module rh_pattern_sequencer
   import rh_pkg::*;
#(
   parameter int ROW_WIDTH  = 15,
   parameter int BANK_WIDTH = 3,
   parameter int MAX_AGGR   = 8,
   parameter int CNT_WIDTH  = 24,
   parameter int AW         = $clog2(MAX_AGGR) + 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [BANK_WIDTH-1:0] i_cfg_bank,
   input  logic [ROW_WIDTH-1:0]  i_cfg_base_row,
   input  logic [ROW_WIDTH-1:0]  i_cfg_stride,
   input  logic [AW-1:0]         i_cfg_num_aggr,
   input  logic [CNT_WIDTH-1:0]  i_cfg_hammer_cnt,
   input  logic                  i_cfg_mode,
   input  logic                  i_abort,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [31:0]           o_instr0,
   output logic                  o_valid0,
   input  logic                  i_ack0,
   output logic [31:0]           o_instr1,
   output logic                  o_valid1,
   input  logic                  i_ack1,
   output logic [CNT_WIDTH-1:0]  o_iter_count
);
   rh_state_e r_state, w_next;

   logic [BANK_WIDTH-1:0] r_bank;
   logic [ROW_WIDTH-1:0]  r_base;
   logic [ROW_WIDTH-1:0]  r_stride;
   logic [AW-1:0]         r_num;
   logic [CNT_WIDTH-1:0]  r_hammer;
   logic                  r_mode;
   logic                  r_abort_pend;

   logic [AW-1:0]         w_num_clamped;
   logic [ROW_WIDTH-1:0]  w_row;
   logic                  w_last_pair;
   logic                  w_abort;
   logic                  w_pair_done;
   logic                  w_run_end;
   logic [31:0]           w_instr0;
   logic [31:0]           w_instr1;

   assign w_num_clamped = (i_cfg_num_aggr > AW'(MAX_AGGR)) ? AW'(MAX_AGGR) : i_cfg_num_aggr;
   assign w_abort       = r_abort_pend | i_abort;
   // A slot counts as acked once its valid has already dropped or it is being acked now.
   assign w_pair_done   = (r_state == ST_WAIT_ACK) && (!o_valid0 || i_ack0) && (!o_valid1 || i_ack1);
   assign w_run_end     = w_last_pair && (CNT_WIDTH'(o_iter_count + 1'b1) == r_hammer);

   assign o_busy = (r_state != ST_IDLE);
   assign o_done = (r_state == ST_DONE);

   rh_row_stepper #(
      .ROW_WIDTH (ROW_WIDTH),
      .AW        (AW)
   ) u_stepper (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_load      (r_state == ST_LOAD),
      .i_step      (w_pair_done),
      .i_base      (r_base),
      .i_stride    (r_stride),
      .i_num       (r_num),
      .i_mode      (r_mode),
      .o_row       (w_row),
      .o_last_pair (w_last_pair)
   );

   always_comb begin
      w_instr0 = '0;
      w_instr0[INSTR_OP_LSB +: INSTR_OP_W]  = OP_ACT;
      w_instr0[INSTR_BANK_LSB +: BANK_WIDTH] = r_bank;
      w_instr0[INSTR_ROW_LSB +: ROW_WIDTH]   = w_row;
      w_instr1 = '0;
      w_instr1[INSTR_OP_LSB +: INSTR_OP_W]  = OP_PRE;
      w_instr1[INSTR_BANK_LSB +: BANK_WIDTH] = r_bank;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:     if (i_start) w_next = ST_LOAD;
         ST_LOAD:     w_next = ((r_num == '0) || (r_hammer == '0) || w_abort) ? ST_DONE : ST_ISSUE;
         ST_ISSUE:    w_next = w_abort ? ST_DONE : ST_WAIT_ACK;
         ST_WAIT_ACK: if (w_pair_done) w_next = (w_run_end || w_abort) ? ST_DONE : ST_ISSUE;
         ST_DONE:     w_next = ST_IDLE;
         default:     w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_bank       <= '0;
         r_base       <= '0;
         r_stride     <= '0;
         r_num        <= '0;
         r_hammer     <= '0;
         r_mode       <= 1'b0;
         r_abort_pend <= 1'b0;
         o_instr0     <= '0;
         o_instr1     <= '0;
         o_valid0     <= 1'b0;
         o_valid1     <= 1'b0;
         o_iter_count <= '0;
      end else begin
         if (r_state == ST_IDLE)  r_abort_pend <= 1'b0;
         else if (i_abort)        r_abort_pend <= 1'b1;

         if ((r_state == ST_IDLE) && i_start) begin
            r_bank       <= i_cfg_bank;
            r_base       <= i_cfg_base_row;
            r_stride     <= i_cfg_stride;
            r_num        <= w_num_clamped;
            r_hammer     <= i_cfg_hammer_cnt;
            r_mode       <= i_cfg_mode;
            o_iter_count <= '0;
         end

         if ((r_state == ST_ISSUE) && !w_abort) begin
            o_instr0 <= w_instr0;
            o_instr1 <= w_instr1;
            o_valid0 <= 1'b1;
            o_valid1 <= 1'b1;
         end

         if (r_state == ST_WAIT_ACK) begin
            if (i_ack0) o_valid0 <= 1'b0;
            if (i_ack1) o_valid1 <= 1'b0;
            if (w_pair_done && w_last_pair) o_iter_count <= o_iter_count + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_rh_pattern_sequencer.sv
// tb/tb_rh_pattern_sequencer.sv - self-checking bench for rh_pattern_sequencer
module tb_rh_pattern_sequencer;
   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_start;
   logic [2:0]  i_cfg_bank;
   logic [14:0] i_cfg_base_row;
   logic [14:0] i_cfg_stride;
   logic [3:0]  i_cfg_num_aggr;
   logic [23:0] i_cfg_hammer_cnt;
   logic        i_cfg_mode;
   logic        i_abort;
   logic        o_busy, o_done, o_valid0, o_valid1;
   logic [31:0] o_instr0, o_instr1;
   logic        i_ack0, i_ack1;
   logic [23:0] o_iter_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 i_clk = ~i_clk;

   rh_pattern_sequencer dut (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_start          (i_start),
      .i_cfg_bank       (i_cfg_bank),
      .i_cfg_base_row   (i_cfg_base_row),
      .i_cfg_stride     (i_cfg_stride),
      .i_cfg_num_aggr   (i_cfg_num_aggr),
      .i_cfg_hammer_cnt (i_cfg_hammer_cnt),
      .i_cfg_mode       (i_cfg_mode),
      .i_abort          (i_abort),
      .o_busy           (o_busy),
      .o_done           (o_done),
      .o_instr0         (o_instr0),
      .o_valid0         (o_valid0),
      .i_ack0           (i_ack0),
      .o_instr1         (o_instr1),
      .o_valid1         (o_valid1),
      .i_ack1           (i_ack1),
      .o_iter_count     (o_iter_count)
   );

   typedef struct {
      logic        mode;
      logic [14:0] base;
      logic [14:0] stride;
      logic [3:0]  n;
      logic [23:0] hc;
      logic [2:0]  bank;
      int          ackm;
      int          abort_at;
      int          exp_pairs;
      int          exp_iter;
      int          exp_lat;
      logic [14:0] exp_first;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic check_all_zero(input string nm);
      chk({nm, "_busy"}, o_busy, 0);
      chk({nm, "_done"}, o_done, 0);
      chk({nm, "_valid"}, {o_valid0, o_valid1}, 0);
      chk({nm, "_instr0"}, o_instr0, 0);
      chk({nm, "_instr1"}, o_instr1, 0);
      chk({nm, "_iter"}, o_iter_count, 0);
   endtask

   // ackm: 0 = always ready, 1 = random acks, 2 = ack0 on issue cycle and ack1 three cycles later
   task automatic run_cfg(input logic mode, input logic [14:0] base, input logic [14:0] stride,
                          input logic [3:0] n, input logic [23:0] hc, input logic [2:0] bank,
                          input int ackm, input int abort_at,
                          output int pairs, output int iter, output int done_lat,
                          output logic [14:0] first_row);
      logic [14:0] exp_q[$];
      logic [14:0] row;
      int          n_eff, cyc, last_issue, issue_cyc, last_ack, tmp;
      logic        pv0, pv1, pa0, pa1, a0, a1, got0, got1, fin, seen_done;
      logic [31:0] h0, h1;

      n_eff = (n > 4'd8) ? 8 : int'(n);
      exp_q = {};
      for (int p = 0; p < int'(hc) && exp_q.size() < 64; p++) begin
         for (int i = 0; i < n_eff; i++) begin
            tmp = int'(base) + i * int'(stride);
            if (mode == 1'b0) begin
               exp_q.push_back(tmp[14:0]);
            end else begin
               tmp = tmp - 1;
               exp_q.push_back(tmp[14:0]);
               tmp = tmp + 2;
               exp_q.push_back(tmp[14:0]);
            end
         end
      end

      pairs = 0; iter = 0; done_lat = 0; first_row = '0;
      cyc = 0; last_issue = 0; issue_cyc = 0; last_ack = 0;
      pv0 = 0; pv1 = 0; pa0 = 0; pa1 = 0; got0 = 0; got1 = 0;
      fin = 0; seen_done = 0; h0 = '0; h1 = '0;

      i_cfg_mode = mode; i_cfg_base_row = base; i_cfg_stride = stride;
      i_cfg_num_aggr = n; i_cfg_hammer_cnt = hc; i_cfg_bank = bank;
      i_start = 1'b1;

      while (!fin && cyc < 3000) begin
         @(negedge i_clk);
         cyc++;
         i_start = 1'b0;
         i_abort = 1'b0;
         if (cyc == 1) begin
            i_cfg_mode       = 1'($urandom);
            i_cfg_base_row   = 15'($urandom);
            i_cfg_stride     = 15'($urandom);
            i_cfg_num_aggr   = 4'($urandom);
            i_cfg_hammer_cnt = 24'($urandom);
            i_cfg_bank       = 3'($urandom);
         end
         if (seen_done) begin
            chk("done_one_cycle", o_done, 0);
            chk("idle_after_done", o_busy, 0);
            chk("iter_hold", o_iter_count, iter);
            fin = 1;
         end else begin
            if (pv0) chk("valid0_hold", o_valid0, !pa0);
            if (pv1) chk("valid1_hold", o_valid1, !pa1);
            if (o_valid0 && !pv0) begin
               pairs++;
               chk("pair_together", o_valid1, 1);
               chk("issue_after_acks", pv1, 0);
               if (ackm == 0 && pairs > 1) chk("pair_gap", cyc - last_issue, 2);
               last_issue = cyc;
               issue_cyc  = cyc;
               got0 = 0; got1 = 0;
               if (pairs == 1) first_row = o_instr0[14:0];
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL extra_pair: pair %0d issued with instr0 0x%0h, none expected", pairs, o_instr0);
               end else begin
                  row = exp_q.pop_front();
                  chk("instr0", o_instr0, {3'b001, bank, 11'd0, row});
                  chk("instr1", o_instr1, {3'b010, bank, 26'd0});
               end
               h0 = o_instr0;
               h1 = o_instr1;
               if (pairs == abort_at) i_abort = 1'b1;
               if (pairs == 2) i_start = 1'b1;
            end else if (o_valid0) begin
               chk("instr0_stable", o_instr0, h0);
            end
            if (o_valid1 && pv1) chk("instr1_stable", o_instr1, h1);

            if (o_done) begin
               seen_done = 1;
               done_lat  = cyc;
               iter      = int'(o_iter_count);
               chk("busy_in_done", o_busy, 1);
               chk("no_valid_in_done", {o_valid0, o_valid1}, 0);
               if (pairs > 0) chk("done_after_last_ack", cyc, last_ack + 1);
            end else begin
               chk("busy_running", o_busy, 1);
            end

            case (ackm)
               0:       begin a0 = 1'b1; a1 = 1'b1; end
               2:       begin a0 = (cyc == issue_cyc); a1 = (cyc == issue_cyc + 3); end
               default: begin a0 = 1'($urandom); a1 = 1'($urandom); end
            endcase
            i_ack0 = a0;
            i_ack1 = a1;
            if (o_valid0 && a0) got0 = 1;
            if (o_valid1 && a1) got1 = 1;
            if (got0 && got1 && ((o_valid0 && a0) || (o_valid1 && a1))) last_ack = cyc;
            pv0 = o_valid0; pv1 = o_valid1; pa0 = a0; pa1 = a1;
         end
      end
      if (!fin) begin
         n_checks++;
         n_errors++;
         $display("FAIL run_timeout: no completion after %0d cycles, pairs=%0d", cyc, pairs);
      end
      i_ack0 = 1'b0;
      i_ack1 = 1'b0;
   endtask

   initial begin
      int          pairs, iter, lat, total, len, exp_pairs, abort_at, n_eff;
      logic [14:0] first;
      logic        mode;
      logic [3:0]  n;
      logic [23:0] hc;

      tbl[0] = '{1'b0, 15'd100,    15'd4,    4'd3,  24'd2,        3'd1, 0, 0, 6, 2, 14, 15'd100};
      tbl[1] = '{1'b1, 15'd0,      15'd10,   4'd2,  24'd1,        3'd5, 0, 0, 4, 1, 10, 15'h7FFF};
      tbl[2] = '{1'b0, 15'd20,     15'd1,    4'd0,  24'd5,        3'd2, 0, 0, 0, 0, 2,  15'd0};
      tbl[3] = '{1'b0, 15'd20,     15'd1,    4'd3,  24'd0,        3'd2, 0, 0, 0, 0, 2,  15'd0};
      tbl[4] = '{1'b0, 15'd7,      15'd1,    4'd12, 24'd1,        3'd4, 0, 0, 8, 1, 18, 15'd7};
      tbl[5] = '{1'b1, 15'd200,    15'd2,    4'd2,  24'd1,        3'd3, 2, 0, 4, 1, 0,  15'd199};
      tbl[6] = '{1'b0, 15'd50,     15'd3,    4'd4,  24'd2,        3'd6, 0, 3, 3, 0, 8,  15'd50};
      tbl[7] = '{1'b1, 15'd1000,   15'd5,    4'd2,  24'd2,        3'd7, 1, 3, 3, 0, 0,  15'd999};
      tbl[8] = '{1'b0, 15'h7FF0,   15'h10,   4'd3,  24'd1,        3'd0, 0, 0, 3, 1, 8,  15'h7FF0};
      tbl[9] = '{1'b0, 15'd300,    15'd0,    4'd1,  24'hFFFFFF,   3'd2, 0, 3, 3, 3, 8,  15'd300};

      i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_ack0 = 1'b0; i_ack1 = 1'b0;
      i_cfg_bank = '0; i_cfg_base_row = '0; i_cfg_stride = '0; i_cfg_num_aggr = '0;
      i_cfg_hammer_cnt = '0; i_cfg_mode = 1'b0;
      repeat (3) @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);
      check_all_zero("reset");

      for (int k = 0; k < 10; k++) begin
         run_cfg(tbl[k].mode, tbl[k].base, tbl[k].stride, tbl[k].n, tbl[k].hc, tbl[k].bank,
                 tbl[k].ackm, tbl[k].abort_at, pairs, iter, lat, first);
         chk($sformatf("vec%0d_pairs", k), pairs, tbl[k].exp_pairs);
         chk($sformatf("vec%0d_iter", k), iter, tbl[k].exp_iter);
         if (tbl[k].exp_lat != 0) chk($sformatf("vec%0d_done_latency", k), lat, tbl[k].exp_lat);
         if (tbl[k].exp_pairs > 0) chk($sformatf("vec%0d_first_row", k), first, tbl[k].exp_first);
         repeat (2) @(negedge i_clk);
      end

      // Reset in the middle of WAIT_ACK, then a clean rerun from the base row.
      i_cfg_mode = 1'b0; i_cfg_base_row = 15'd100; i_cfg_stride = 15'd4;
      i_cfg_num_aggr = 4'd3; i_cfg_hammer_cnt = 24'd2; i_cfg_bank = 3'd1;
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      for (int c = 0; c < 10 && !o_valid0; c++) @(negedge i_clk);
      chk("rst_seq_valid_up", o_valid0, 1);
      @(negedge i_clk);
      chk("rst_seq_waiting", o_valid0, 1);
      i_rst = 1'b1;
      @(negedge i_clk);
      check_all_zero("midrun_reset");
      i_rst = 1'b0;
      @(negedge i_clk);
      run_cfg(1'b0, 15'd100, 15'd4, 4'd3, 24'd2, 3'd1, 0, 0, pairs, iter, lat, first);
      chk("after_reset_pairs", pairs, 6);
      chk("after_reset_first_row", first, 15'd100);
      chk("after_reset_iter", iter, 2);
      repeat (2) @(negedge i_clk);

      for (int r = 0; r < 12; r++) begin
         mode  = 1'($urandom);
         n     = 4'($urandom);
         hc    = 24'($urandom_range(0, 3));
         n_eff = (n > 4'd8) ? 8 : int'(n);
         len   = n_eff * (mode ? 2 : 1);
         total = len * int'(hc);
         abort_at = (total > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, total)) : 0;
         exp_pairs = (abort_at > 0) ? abort_at : total;
         run_cfg(mode, 15'($urandom), 15'($urandom), n, hc, 3'($urandom),
                 1, abort_at, pairs, iter, lat, first);
         chk($sformatf("rand%0d_pairs", r), pairs, exp_pairs);
         chk($sformatf("rand%0d_iter", r), iter, (len > 0) ? exp_pairs / len : 0);
         repeat (2) @(negedge i_clk);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
